uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver. Input is a serial frame of 1 start bit (0), 8 data bits (LSB first) and 1 stop bit (1).
- Oversamples the line at 16x the baud rate, decides each bit at its mid-point, and presents each received byte with a one-cycle valid strobe.
- Sits between the external RX pin and the host/FIFO logic. It is the receive-side counterpart of the UART transmitter and shares its baud generator's 16x tick.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronising rx_line into clk; legal range 2..3.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- baud_tick_16x  input  1  one-clk pulse at 16x the baud rate
- rx_line  input  1  asynchronous serial input; idle high
- rx_data  output  8  last good received byte; held until the next good frame
- rx_valid  output  1  one-clk pulse when rx_data is updated
- rx_busy  output  1  high from start-bit detect until return to IDLE
- frame_err  output  1  one-clk pulse when the stop bit is sampled low
- parity_err  output  1  one-clk pulse on parity mismatch; tied 0 without the macro

Behaviour:
- Reset (async, rst_n low): rx_data=8'h00; rx_valid=0; rx_busy=0; frame_err=0; parity_err=0; state=IDLE; synchroniser flops=1; tick counter=0; bit counter=0.
- Synchroniser: rx_line passes through SYNC_STAGES flops, giving rx_s. All decisions use rx_s only.
- Tick counter: 4 bits, increments only on baud_tick_16x, reset to 0 on every state entry.
- State IDLE:
  - On a baud_tick_16x with rx_s==0: go to START, set rx_busy=1.
- State START:
  - On the tick where the counter==7 (mid start bit): rx_s==0 → DATA (counter=0, bit counter=0); rx_s==1 → glitch, back to IDLE with rx_busy=0 and no error flag.
- State DATA:
  - On the tick where the counter==15: shift rx_s into the shift register MSB (shift right) and increment the bit counter.
  - After the 8th sample: go to PARITY (macro defined) or STOP.
- State STOP, on the tick where the counter==15:
  - rx_s==1 → next clk: rx_data=shift register, rx_valid=1 for exactly one clk, go to IDLE, rx_busy=0.
  - rx_s==0 → frame_err=1 for one clk, rx_data unchanged, rx_valid stays 0, go to WAIT_IDLE.
- State WAIT_IDLE:
  - Stays until a baud_tick_16x with rx_s==1, then goes to IDLE and drops rx_busy. This prevents a break condition from being read as back-to-back 0x00 frames.
- Timing and latency:
  - Bits are sampled 8/16 + 16n ticks after the first low tick.
  - rx_valid rises one clk after the mid-stop-bit sampling tick.
  - rx_line to rx_s adds SYNC_STAGES clks.
- Back-to-back frames: after rx_valid the FSM is in IDLE. A start edge arriving in the second half of the stop bit is detected on the following tick, so there are no lost frames at 0 idle bits.
- No flow control: the host must consume rx_data before the next rx_valid; a new good frame overwrites it.
- baud_tick_16x low: the FSM holds state and all counters.
- rst_n asserted mid-frame: everything returns to reset values immediately with no pulses. After release, a line that is still low is treated as a new start (START/glitch rules apply).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 11 bits; the PARITY state sits between DATA and STOP.
  - The parity bit is sampled on the tick where the counter==15.
  - The expected bit is ^data for PARITY_ODD=0 and ~^data for PARITY_ODD=1.
  - On mismatch, parity_err pulses one clk together with the STOP-state outcome and rx_valid is suppressed; frame_err is still checked independently.
- Undefined:
  - 10-bit frame, no PARITY state, parity_err constant 0.

Test Plan:
- Byte 8'hA5 sent at 16 ticks/bit, 2 idle bits → rx_data=8'hA5, exactly one rx_valid pulse, frame_err=0, rx_busy high for the frame.
- Frames 8'h00, 8'hFF, 8'h3C back-to-back with zero idle bits → three rx_valid pulses in order with matching rx_data, no errors.
- rx_line low for 5 ticks, then high → no rx_valid, no frame_err, rx_busy returns to 0 by tick 8.
- Frame 8'h55 with stop bit forced 0, then line held low 40 ticks, then high → one frame_err pulse, rx_data keeps its previous value, no rx_valid, IDLE only after the line goes high.
- rst_n pulsed low during data bit 4 of 8'hC3, then a clean 8'h81 frame → no outputs from the aborted frame; rx_data=8'h81 with one rx_valid.
- UART_RX_PARITY_EN, PARITY_ODD=0:
  - 8'h07 with parity bit 1 → rx_valid, no parity_err.
  - 8'h07 with parity bit 0 → parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, 8N1 frames with one-clk valid/error strobes.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick_16x,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       par_bad_q, par_bad_d;
    logic       perr_q, perr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_line};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    localparam logic ParOdd = (PARITY_ODD != 0);
`else
    logic unused_parity_odd;
    assign unused_parity_odd = ^PARITY_ODD;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_bad_d = par_bad_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        if (baud_tick_16x) begin
            cnt_d = cnt_q + 4'd1;
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (cnt_q == 4'd7) begin
                        state_d   = rx_s ? StIdle : StData;
                        bit_cnt_d = 3'd0;
                        par_bad_d = 1'b0;
                    end
                end
                StData: begin
                    if (cnt_q == 4'd15) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end
                end
                StParity: begin
`ifdef UART_RX_PARITY_EN
                    if (cnt_q == 4'd15) begin
                        par_bad_d = rx_s != ((^shift_q) ^ ParOdd);
                        state_d   = StStop;
                    end
`else
                    state_d = StIdle;
`endif
                end
                StStop: begin
                    if (cnt_q == 4'd15) begin
                        perr_d = par_bad_q;
                        if (rx_s) begin
                            state_d = StIdle;
                            if (!par_bad_q) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end
                        end else begin
                            // Stop bit low: wait for the line to go idle so a break is one error.
                            state_d = StWaitIdle;
                            ferr_d  = 1'b1;
                        end
                    end
                end
                StWaitIdle: begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (state_d != state_q) begin
                cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != StIdle);
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
    logic unused_perr;
    assign unused_perr = perr_q ^ par_bad_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back, glitch, framing error, mid-frame reset.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick_16x;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_tick_16x (baud_tick_16x),
        .rx_line       (rx_line),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy),
        .frame_err     (frame_err),
        .parity_err    (parity_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] rx_hist[$];
    logic       busy_ok;

    // Every clk an output pulse is high counts once, so a stuck pulse over-counts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                valid_cnt++;
                last_data = rx_data;
                rx_hist.push_back(rx_data);
            end
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        repeat (3) @(negedge clk);
        baud_tick_16x = 1'b1;
        @(negedge clk);
        baud_tick_16x = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        busy_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            busy_ok = busy_ok & rx_busy;
        end
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    initial begin
        rst_n         = 1'b0;
        baud_tick_16x = 1'b0;
        rx_line       = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_rx_busy", rx_busy, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_parity_err", parity_err, 1'b0);
        rst_n = 1'b1;
        ticks(4);

        // Single good frame after two idle bits.
        ticks(32);
        send_frame(8'hA5, 1'b1, 1'b0);
        ticks(32);
        chk("a5_valid_cnt", valid_cnt, 1);
        chk("a5_data", last_data, 8'hA5);
        chk("a5_rx_data_held", rx_data, 8'hA5);
        chk("a5_frame_err", ferr_cnt, 0);
        chk("a5_busy_during", busy_ok, 1'b1);
        chk("a5_busy_after", rx_busy, 1'b0);

        // Back-to-back frames, zero idle bits.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        ticks(32);
        chk("b2b_valid_cnt", valid_cnt, 4);
        chk("b2b_data0", rx_hist[1], 8'h00);
        chk("b2b_data1", rx_hist[2], 8'hFF);
        chk("b2b_data2", rx_hist[3], 8'h3C);
        chk("b2b_frame_err", ferr_cnt, 0);

        // Start-bit glitch: low for 5 ticks only.
        rx_line = 1'b0;
        ticks(5);
        chk("glitch_busy_start", rx_busy, 1'b1);
        rx_line = 1'b1;
        ticks(4);
        chk("glitch_busy_end", rx_busy, 1'b0);
        ticks(16);
        chk("glitch_valid_cnt", valid_cnt, 4);
        chk("glitch_frame_err", ferr_cnt, 0);

        // Framing error followed by a 40-tick break.
        send_frame(8'h55, 1'b0, 1'b0);
        ticks(40);
        chk("ferr_busy_break", rx_busy, 1'b1);
        chk("ferr_cnt", ferr_cnt, 1);
        chk("ferr_valid_cnt", valid_cnt, 4);
        chk("ferr_rx_data_kept", rx_data, 8'h3C);
        rx_line = 1'b1;
        tick();
        chk("ferr_idle_after_high", rx_busy, 1'b0);
        ticks(16);
        chk("ferr_single_pulse", ferr_cnt, 1);

        // Reset during data bit 4 of 8'hC3, then a clean 8'h81.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_line = 1'b0;
        ticks(5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_valid", rx_valid, 1'b0);
        rx_line = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        ticks(16);
        chk("rst_no_valid", valid_cnt, 4);
        chk("rst_no_ferr", ferr_cnt, 1);
        send_frame(8'h81, 1'b1, 1'b0);
        ticks(32);
        chk("post_rst_valid_cnt", valid_cnt, 5);
        chk("post_rst_data", last_data, 8'h81);
        chk("post_rst_rx_data", rx_data, 8'h81);
        chk("post_rst_ferr", ferr_cnt, 1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        ticks(32);
        chk("par_ok_valid_cnt", valid_cnt, 6);
        chk("par_ok_data", last_data, 8'h07);
        chk("par_ok_perr", perr_cnt, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        ticks(32);
        chk("par_bad_valid_cnt", valid_cnt, 6);
        chk("par_bad_perr", perr_cnt, 1);
        chk("par_bad_ferr", ferr_cnt, 1);
`else
        chk("no_parity_err", perr_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
